// File: rtl/core_pkg.sv
// Shared core types: register-file write request and datapath widths.
// The width macros are normally supplied by config.svh; these are fallbacks.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_AW
`define REG_AW 5
`endif
`ifndef REG_NUM
`define REG_NUM 32
`endif

package core_pkg;

  localparam int unsigned XLEN    = `XLEN;
  localparam int unsigned REG_AW  = `REG_AW;
  localparam int unsigned REG_NUM = `REG_NUM;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// FIFO-ordered buffer for long-latency write-back results.
module wb_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_req_t        mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back controller: arbitrates pipe vs buffered long-latency results,
// bounds buffer starvation, tracks pending destinations and forwards writes.
module wb_ctrl
  import core_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned LCU_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic [REG_AW-1:0] pipe_rd_addr,
  input  logic [XLEN-1:0]   pipe_wdata,
  output logic              pipe_stall,
  input  logic              lcu_valid,
  output logic              lcu_ready,
  input  logic [REG_AW-1:0] lcu_rd_addr,
  input  logic [XLEN-1:0]   lcu_wdata,
  input  logic              sb_set,
  input  logic [REG_AW-1:0] sb_set_addr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              fwd_rs1_hit,
  output logic              fwd_rs2_hit,
  output logic [XLEN-1:0]   fwd_rs1_data,
  output logic [XLEN-1:0]   fwd_rs2_data,
  output logic [REG_AW-1:0] rd_addr,
  output logic [XLEN-1:0]   rd_wdata,
  output logic              rd_write
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]      starve_cnt;
  logic [REG_NUM-1:0] sb_q;
  logic [REG_NUM-1:0] sb_next;
  wb_req_t            lcu_req;
  wb_req_t            head;
  logic               full;
  logic               empty;
  logic               push;
  logic               sel_head;
  logic               sel_pipe;

  assign lcu_req   = '{addr: lcu_rd_addr, data: lcu_wdata};
  assign lcu_ready = !full;
  assign push      = lcu_valid && !full;

  wb_fifo #(.DEPTH(LCU_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (lcu_req),
    .pop       (sel_head),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Pipe has priority unless the buffer has waited STARVE_MAX pipe wins.
  always_comb begin
    sel_head = 1'b0;
    sel_pipe = 1'b0;
    if (!rst) begin
      if (!empty && (starve_cnt == SW'(STARVE_MAX) || !pipe_valid)) sel_head = 1'b1;
      else if (pipe_valid)                                            sel_pipe = 1'b1;
    end
  end

  always_comb begin
    rd_addr  = '0;
    rd_wdata = '0;
    if (sel_head) begin
      rd_addr  = head.addr;
      rd_wdata = head.data;
    end else if (sel_pipe) begin
      rd_addr  = pipe_rd_addr;
      rd_wdata = pipe_wdata;
    end
  end

  assign rd_write   = (sel_head || sel_pipe) && (rd_addr != '0);
  assign pipe_stall = pipe_valid && sel_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                   starve_cnt <= '0;
    else if (sel_head || empty)                                starve_cnt <= '0;
    else if (sel_pipe && starve_cnt != SW'(STARVE_MAX))        starve_cnt <= starve_cnt + SW'(1);
  end

  // Set wins over clear; only buffered (long-latency) writes clear.
  always_comb begin
    sb_next = sb_q;
    if (sel_head && head.addr != '0)     sb_next[head.addr]   = 1'b0;
    if (sb_set && sb_set_addr != '0)     sb_next[sb_set_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_next;
  end

  assign rs1_busy     = (rs1_addr != '0) && sb_q[rs1_addr];
  assign rs2_busy     = (rs2_addr != '0) && sb_q[rs2_addr];
  assign fwd_rs1_hit  = rd_write && (rd_addr == rs1_addr);
  assign fwd_rs2_hit  = rd_write && (rd_addr == rs2_addr);
  assign fwd_rs1_data = rd_wdata;
  assign fwd_rs2_data = rd_wdata;

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_wb_ctrl;
  import core_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int LCU_DEPTH  = 2;

  logic              clk;
  logic              rst;
  logic              pipe_valid;
  logic [REG_AW-1:0] pipe_rd_addr;
  logic [XLEN-1:0]   pipe_wdata;
  logic              pipe_stall;
  logic              lcu_valid;
  logic              lcu_ready;
  logic [REG_AW-1:0] lcu_rd_addr;
  logic [XLEN-1:0]   lcu_wdata;
  logic              sb_set;
  logic [REG_AW-1:0] sb_set_addr;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              fwd_rs1_hit;
  logic              fwd_rs2_hit;
  logic [XLEN-1:0]   fwd_rs1_data;
  logic [XLEN-1:0]   fwd_rs2_data;
  logic [REG_AW-1:0] rd_addr;
  logic [XLEN-1:0]   rd_wdata;
  logic              rd_write;

  int n_vec = 0;
  int n_err = 0;

  wb_ctrl #(.STARVE_MAX(STARVE_MAX), .LCU_DEPTH(LCU_DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_valid   (pipe_valid),
    .pipe_rd_addr (pipe_rd_addr),
    .pipe_wdata   (pipe_wdata),
    .pipe_stall   (pipe_stall),
    .lcu_valid    (lcu_valid),
    .lcu_ready    (lcu_ready),
    .lcu_rd_addr  (lcu_rd_addr),
    .lcu_wdata    (lcu_wdata),
    .sb_set       (sb_set),
    .sb_set_addr  (sb_set_addr),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .fwd_rs1_hit  (fwd_rs1_hit),
    .fwd_rs2_hit  (fwd_rs2_hit),
    .fwd_rs1_data (fwd_rs1_data),
    .fwd_rs2_data (fwd_rs2_data),
    .rd_addr      (rd_addr),
    .rd_wdata     (rd_wdata),
    .rd_write     (rd_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    pipe_valid   = 1'b0;
    pipe_rd_addr = '0;
    pipe_wdata   = '0;
    lcu_valid    = 1'b0;
    lcu_rd_addr  = '0;
    lcu_wdata    = '0;
    sb_set       = 1'b0;
    sb_set_addr  = '0;
    rs1_addr     = '0;
    rs2_addr     = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    pipe_valid = 1'b1; pipe_rd_addr = REG_AW'(3); rs1_addr = REG_AW'(3);
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (rd_write !== 1'b0) begin n_err++; $display("FAIL rst_write: got %0b want 0", rd_write); end
    n_vec++; if (pipe_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0b want 0", pipe_stall); end
    n_vec++; if (lcu_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b want 1", lcu_ready); end
    n_vec++; if (fwd_rs1_hit !== 1'b0) begin n_err++; $display("FAIL rst_fwd: got %0b want 0", fwd_rs1_hit); end
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    rs1_addr = REG_AW'(5);
    #1;
    n_vec++; if (rd_write !== 1'b0) begin n_err++; $display("FAIL idle_write: got %0b want 0", rd_write); end
    n_vec++; if (lcu_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready: got %0b want 1", lcu_ready); end
    n_vec++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %0b want 0", rs1_busy); end
  endtask

  task automatic test_lcu_single();
    @(negedge clk);
    sb_set = 1'b1; sb_set_addr = REG_AW'(5);
    @(negedge clk);
    sb_set = 1'b0; rs1_addr = REG_AW'(5);
    lcu_valid = 1'b1; lcu_rd_addr = REG_AW'(5); lcu_wdata = 32'hDEADBEEF;
    #1;
    n_vec++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL single_busy_set: got %0b want 1", rs1_busy); end
    @(negedge clk);
    lcu_valid = 1'b0;
    #1;
    n_vec++; if (rd_write !== 1'b1) begin n_err++; $display("FAIL single_write: got %0b want 1", rd_write); end
    n_vec++; if (rd_addr !== REG_AW'(5)) begin n_err++; $display("FAIL single_addr: got %0d want 5", rd_addr); end
    n_vec++; if (rd_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %h want deadbeef", rd_wdata); end
    @(negedge clk);
    #1;
    n_vec++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_clr: got %0b want 0", rs1_busy); end
    n_vec++; if (rd_write !== 1'b0) begin n_err++; $display("FAIL single_drained: got %0b want 0", rd_write); end
    drive_idle();
  endtask

  task automatic test_starve();
    @(negedge clk);
    pipe_valid = 1'b1; pipe_rd_addr = REG_AW'(1); pipe_wdata = 32'h1111;
    lcu_valid = 1'b1; lcu_rd_addr = REG_AW'(10); lcu_wdata = 32'hA0A0;
    @(negedge clk);
    lcu_rd_addr = REG_AW'(11); lcu_wdata = 32'hB0B0;
    for (int i = 0; i < STARVE_MAX; i++) begin
      #1;
      n_vec++; if (pipe_stall !== 1'b0 || rd_addr !== REG_AW'(1)) begin
        n_err++; $display("FAIL starve_pipe1[%0d]: got stall=%0b addr=%0d want 0/1", i, pipe_stall, rd_addr); end
      @(negedge clk);
      lcu_valid = 1'b0;
    end
    #1;
    n_vec++; if (pipe_stall !== 1'b1 || rd_addr !== REG_AW'(10) || rd_wdata !== 32'hA0A0) begin
      n_err++; $display("FAIL starve_head1: got stall=%0b addr=%0d data=%h want 1/10/a0a0", pipe_stall, rd_addr, rd_wdata); end
    for (int i = 0; i < STARVE_MAX; i++) begin
      @(negedge clk);
      #1;
      n_vec++; if (pipe_stall !== 1'b0 || rd_addr !== REG_AW'(1)) begin
        n_err++; $display("FAIL starve_pipe2[%0d]: got stall=%0b addr=%0d want 0/1", i, pipe_stall, rd_addr); end
    end
    @(negedge clk);
    #1;
    n_vec++; if (pipe_stall !== 1'b1 || rd_addr !== REG_AW'(11) || rd_wdata !== 32'hB0B0) begin
      n_err++; $display("FAIL starve_head2: got stall=%0b addr=%0d data=%h want 1/11/b0b0", pipe_stall, rd_addr, rd_wdata); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_full();
    @(negedge clk);
    pipe_valid = 1'b1; pipe_rd_addr = REG_AW'(2); pipe_wdata = 32'h22;
    lcu_valid = 1'b1; lcu_rd_addr = REG_AW'(12); lcu_wdata = 32'h1200;
    @(negedge clk);
    lcu_rd_addr = REG_AW'(13); lcu_wdata = 32'h1300;
    #1;
    n_vec++; if (lcu_ready !== 1'b1) begin n_err++; $display("FAIL full_ready1: got %0b want 1", lcu_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin lcu_rd_addr = REG_AW'(14); lcu_wdata = 32'h1400; end
      #1;
      n_vec++; if (lcu_ready !== 1'b0) begin n_err++; $display("FAIL full_ready0[%0d]: got %0b want 0", i, lcu_ready); end
    end
    n_vec++; if (pipe_stall !== 1'b1 || rd_addr !== REG_AW'(12)) begin
      n_err++; $display("FAIL full_pop: got stall=%0b addr=%0d want 1/12", pipe_stall, rd_addr); end
    @(negedge clk);
    #1;
    n_vec++; if (lcu_ready !== 1'b1) begin n_err++; $display("FAIL full_reopen: got %0b want 1", lcu_ready); end
    @(negedge clk);
    drive_idle();
    #1;
    n_vec++; if (rd_write !== 1'b1 || rd_addr !== REG_AW'(13)) begin
      n_err++; $display("FAIL full_drain13: got wr=%0b addr=%0d want 1/13", rd_write, rd_addr); end
    @(negedge clk);
    #1;
    n_vec++; if (rd_addr !== REG_AW'(14) || rd_wdata !== 32'h1400) begin
      n_err++; $display("FAIL full_drain14: got addr=%0d data=%h want 14/1400", rd_addr, rd_wdata); end
    @(negedge clk);
    #1;
    n_vec++; if (rd_write !== 1'b0) begin n_err++; $display("FAIL full_empty: got %0b want 0", rd_write); end
  endtask

  task automatic test_set_clear();
    @(negedge clk);
    lcu_valid = 1'b1; lcu_rd_addr = REG_AW'(7); lcu_wdata = 32'h77;
    @(negedge clk);
    lcu_valid = 1'b0; sb_set = 1'b1; sb_set_addr = REG_AW'(7);
    #1;
    n_vec++; if (rd_write !== 1'b1 || rd_addr !== REG_AW'(7)) begin
      n_err++; $display("FAIL setclr_write: got wr=%0b addr=%0d want 1/7", rd_write, rd_addr); end
    @(negedge clk);
    sb_set = 1'b0; rs1_addr = REG_AW'(7);
    #1;
    n_vec++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL setclr_busy: got %0b want 1", rs1_busy); end
    lcu_valid = 1'b1; lcu_wdata = 32'h78;
    @(negedge clk);
    lcu_valid = 1'b0;
    @(negedge clk);
    #1;
    n_vec++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL setclr_clear: got %0b want 0", rs1_busy); end
    drive_idle();
  endtask

  task automatic test_x0_fwd();
    @(negedge clk);
    pipe_valid = 1'b1; pipe_rd_addr = '0; pipe_wdata = 32'h123; rs1_addr = '0;
    #1;
    n_vec++; if (rd_write !== 1'b0) begin n_err++; $display("FAIL x0_write: got %0b want 0", rd_write); end
    n_vec++; if (fwd_rs1_hit !== 1'b0) begin n_err++; $display("FAIL x0_fwd: got %0b want 0", fwd_rs1_hit); end
    @(negedge clk);
    pipe_rd_addr = REG_AW'(3); pipe_wdata = 32'hCAFE; rs2_addr = REG_AW'(3);
    #1;
    n_vec++; if (fwd_rs2_hit !== 1'b1) begin n_err++; $display("FAIL x3_fwd_hit: got %0b want 1", fwd_rs2_hit); end
    n_vec++; if (fwd_rs2_data !== 32'hCAFE) begin n_err++; $display("FAIL x3_fwd_data: got %h want cafe", fwd_rs2_data); end
    @(negedge clk);
    pipe_valid = 1'b0; lcu_valid = 1'b1; lcu_rd_addr = '0; lcu_wdata = 32'h5;
    @(negedge clk);
    lcu_rd_addr = REG_AW'(6); lcu_wdata = 32'h66;
    #1;
    n_vec++; if (rd_write !== 1'b0) begin n_err++; $display("FAIL x0_pop_write: got %0b want 0", rd_write); end
    @(negedge clk);
    lcu_valid = 1'b0;
    #1;
    n_vec++; if (rd_write !== 1'b1 || rd_addr !== REG_AW'(6)) begin
      n_err++; $display("FAIL x0_popped: got wr=%0b addr=%0d want 1/6", rd_write, rd_addr); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    pipe_valid = 1'b1; pipe_rd_addr = REG_AW'(1);
    lcu_valid = 1'b1; lcu_rd_addr = REG_AW'(9); sb_set = 1'b1; sb_set_addr = REG_AW'(9);
    @(negedge clk);
    lcu_rd_addr = REG_AW'(10); sb_set = 1'b0;
    @(negedge clk);
    lcu_valid = 1'b0; rst = 1'b1; rs1_addr = REG_AW'(9);
    #1;
    n_vec++; if (rd_write !== 1'b0 || pipe_stall !== 1'b0) begin
      n_err++; $display("FAIL midrst_out: got wr=%0b stall=%0b want 0/0", rd_write, pipe_stall); end
    n_vec++; if (lcu_ready !== 1'b1 || rs1_busy !== 1'b0) begin
      n_err++; $display("FAIL midrst_state: got ready=%0b busy=%0b want 1/0", lcu_ready, rs1_busy); end
    @(negedge clk);
    rst = 1'b0; pipe_valid = 1'b0;
    #1;
    n_vec++; if (rd_write !== 1'b0) begin n_err++; $display("FAIL midrst_discard: got %0b want 0", rd_write); end
    drive_idle();
  endtask

  task automatic test_random();
    wb_req_t q[$];
    wb_req_t t;
    bit      sbm [REG_NUM];
    int      starve;
    int      prev_size;
    bit      hold_pipe, hold_lcu, e_full, e_hsel, e_psel, e_wr;
    logic [REG_AW-1:0] ea;
    logic [XLEN-1:0]   ed;
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < REG_NUM; i++) sbm[i] = 1'b0;
    starve = 0; hold_pipe = 1'b0; hold_lcu = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (!hold_pipe) begin
        pipe_valid   = ($urandom_range(0, 9) < 7);
        pipe_rd_addr = REG_AW'($urandom_range(0, 7));
        pipe_wdata   = $urandom;
      end
      if (!hold_lcu) begin
        lcu_valid   = ($urandom_range(0, 1) == 1);
        lcu_rd_addr = REG_AW'($urandom_range(0, 7));
        lcu_wdata   = $urandom;
      end
      sb_set      = ($urandom_range(0, 3) == 0);
      sb_set_addr = REG_AW'($urandom_range(0, 7));
      rs1_addr    = REG_AW'($urandom_range(0, 7));
      rs2_addr    = REG_AW'($urandom_range(0, 7));
      #1;
      e_full = (q.size() == LCU_DEPTH);
      e_hsel = (q.size() != 0) && (starve == STARVE_MAX || !pipe_valid);
      e_psel = pipe_valid && !e_hsel;
      ea = '0; ed = '0;
      if (e_hsel) begin ea = q[0].addr; ed = q[0].data; end
      else if (e_psel) begin ea = pipe_rd_addr; ed = pipe_wdata; end
      e_wr = (e_hsel || e_psel) && (ea != 0);
      n_vec++; if (rd_write !== e_wr) begin n_err++; $display("FAIL rnd_write@%0d: got %0b want %0b", cyc, rd_write, e_wr); end
      n_vec++; if (lcu_ready !== !e_full) begin n_err++; $display("FAIL rnd_ready@%0d: got %0b want %0b", cyc, lcu_ready, !e_full); end
      n_vec++; if (pipe_stall !== (pipe_valid && e_hsel)) begin n_err++; $display("FAIL rnd_stall@%0d: got %0b want %0b", cyc, pipe_stall, pipe_valid && e_hsel); end
      n_vec++; if (rs1_busy !== (rs1_addr != 0 && sbm[int'(rs1_addr)])) begin n_err++; $display("FAIL rnd_busy1@%0d: got %0b", cyc, rs1_busy); end
      n_vec++; if (rs2_busy !== (rs2_addr != 0 && sbm[int'(rs2_addr)])) begin n_err++; $display("FAIL rnd_busy2@%0d: got %0b", cyc, rs2_busy); end
      n_vec++; if (fwd_rs1_hit !== (e_wr && ea == rs1_addr)) begin n_err++; $display("FAIL rnd_fwd1@%0d: got %0b", cyc, fwd_rs1_hit); end
      n_vec++; if (fwd_rs2_hit !== (e_wr && ea == rs2_addr)) begin n_err++; $display("FAIL rnd_fwd2@%0d: got %0b", cyc, fwd_rs2_hit); end
      if (e_wr) begin
        n_vec++; if (rd_addr !== ea || rd_wdata !== ed || fwd_rs1_data !== ed) begin
          n_err++; $display("FAIL rnd_port@%0d: got %0d/%h want %0d/%h", cyc, rd_addr, rd_wdata, ea, ed); end
      end
      prev_size = q.size();
      if (e_hsel) begin
        if (q[0].addr != 0) sbm[int'(q[0].addr)] = 1'b0;
        void'(q.pop_front());
      end
      if (sb_set && sb_set_addr != 0) sbm[int'(sb_set_addr)] = 1'b1;
      if (lcu_valid && !e_full) begin
        t.addr = lcu_rd_addr; t.data = lcu_wdata;
        q.push_back(t);
      end
      if (e_hsel || prev_size == 0) starve = 0;
      else if (e_psel && starve < STARVE_MAX) starve++;
      hold_pipe = pipe_valid && e_hsel;
      hold_lcu  = lcu_valid && e_full;
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_lcu_single();
    test_starve();
    test_full();
    test_set_clear();
    test_x0_fwd();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_ctrl.md
WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 Parameters SHALL be: STARVE_MAX, default 4, max consecutive cycles the pipe source may win while the buffer holds data; LCU_DEPTH, default 2, long-latency result buffer entries.
REQ-002 Widths SHALL come from `REG_AW, `XLEN, `REG_NUM in config.svh.
REQ-003 One clock; reset is asynchronous and active-high: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-004 pipe_valid  in  1  in-order pipeline result present this cycle.
REQ-005 pipe_rd_addr  in  REG_AW  pipeline destination register.
REQ-006 pipe_wdata  in  XLEN  pipeline result data.
REQ-007 pipe_stall  out  1  pipe result not taken this cycle; pipe holds its inputs.
REQ-008 lcu_valid, lcu_ready  in/out  1 each  long-latency unit result handshake.
REQ-009 lcu_rd_addr, lcu_wdata  in  REG_AW / XLEN  long-latency unit result.
REQ-010 sb_set, sb_set_addr  in  1 / REG_AW  issue marks destination pending.
REQ-011 rs1_addr, rs2_addr  in  REG_AW  decode-stage source addresses.
REQ-012 rs1_busy, rs2_busy  out  1 each  source pending in scoreboard.
REQ-013 fwd_rs1_hit, fwd_rs2_hit  out  1 each  source equals the register being written this cycle.
REQ-014 fwd_rs1_data, fwd_rs2_data  out  XLEN each  bypass data (= rd_wdata).
REQ-015 rd_addr, rd_wdata, rd_write  out  REG_AW / XLEN / 1  register file write port.

Function
REQ-016 lcu_ready SHALL equal buffer-not-full, derived only from registered state.
REQ-017 A handshake (lcu_valid && lcu_ready) SHALL push {addr, data} into the FIFO-ordered buffer at the clock edge.
REQ-018 Selection SHALL be: if starve_cnt == STARVE_MAX and buffer non-empty, the buffer head is selected and pipe_stall=1 when pipe_valid; else if pipe_valid, pipe is selected; else if buffer non-empty, head is selected; else nothing.
REQ-019 When the head is selected it SHALL pop that cycle; push and pop in the same cycle SHALL both take effect with count unchanged.
REQ-020 starve_cnt SHALL increment when the pipe is selected with the buffer non-empty, reset to 0 when the head pops or the buffer is empty, and saturate at STARVE_MAX.
REQ-021 rd_write SHALL be 1 iff a source is selected and its address is nonzero; x0 results are still consumed or popped.
REQ-022 rd_addr/rd_wdata SHALL combinationally reflect the selected source, with zero latency to the register file port.
REQ-023 The scoreboard (REG_NUM bits) SHALL set bit sb_set_addr on sb_set unless the address is 0, and clear bit rd_addr when a buffer entry is written.
REQ-024 Set and clear of the same bit in one cycle SHALL leave it set; pipe writes SHALL NOT clear bits.
REQ-025 rsN_busy SHALL be the registered scoreboard bit for rsN_addr, and 0 for address 0.
REQ-026 fwd_rsN_hit SHALL be rd_write && rd_addr == rsN_addr; fwd_rsN_data SHALL be rd_wdata.

Reset
REQ-027 While rst is high: buffer empty, lcu_ready=1, starve_cnt=0, scoreboard all 0, rd_write=0, pipe_stall=0, fwd hits 0.
REQ-028 Reset asserted mid-operation SHALL discard buffered results and pending bits without issuing any write.

Structure
REQ-029 Typedef wb_req_t {addr, data} SHALL live in shared package core_pkg.
REQ-030 The buffer SHALL be sub-module wb_fifo (parameter DEPTH, push/pop/full/empty/head), instantiated once.
REQ-031 Scoreboard, arbitration, starvation counter and forwarding SHALL reside in wb_ctrl.

Verification
REQ-032 Reset then idle: rd_write=0, lcu_ready=1, busy=0.
REQ-033 lcu result (x5, 0xDEADBEEF) with pipe idle: the next cycle shows rd_write=1, rd_addr=5, rd_wdata=0xDEADBEEF, and sb bit 5 clears.
REQ-034 pipe_valid held high with two lcu results pushed: pipe wins 4 cycles, then pipe_stall=1 and the head is written; the second head follows after a further 4 pipe cycles.
REQ-035 Buffer full (2 entries, pipe busy): lcu_ready=0; the extra lcu_valid is held and not accepted until a pop occurs.
REQ-036 sb_set x7 and an x7 buffer write in the same cycle: bit 7 stays set and rs1_addr=7 gives rs1_busy=1.
REQ-037 pipe write x0 with rs1_addr=0: rd_write=0 and fwd_rs1_hit=0; pipe write x3 with rs2_addr=3: fwd_rs2_hit=1 and data matches.
